// File: rtl/ble_rx_sync_detector_if.sv
// Bit-stream bundle between the bit slicer, the sync detector and the de-serializer.
// Latency: none (wires only).
// Backpressure: none; the receive side must take one bit per strobe.
//
// Ports (slave = detector side):
//   rx_en, access_addr, payload_bits, channel, bit_in, bit_valid    -> detector
//   bit_out, bit_out_valid, sync_found, frame_done, abort, busy     <- detector
interface ble_rx_sync_detector_if #(
  parameter int LEN_W = 12
);
  logic             rx_en;
  logic [31:0]      access_addr;
  logic [LEN_W-1:0] payload_bits;
  logic [5:0]       channel;
  logic             bit_in;
  logic             bit_valid;
  logic             bit_out;
  logic             bit_out_valid;
  logic             sync_found;
  logic             frame_done;
  logic             abort;
  logic             busy;

  modport master (
    output rx_en, access_addr, payload_bits, channel, bit_in, bit_valid,
    input  bit_out, bit_out_valid, sync_found, frame_done, abort, busy
  );

  modport slave (
    input  rx_en, access_addr, payload_bits, channel, bit_in, bit_valid,
    output bit_out, bit_out_valid, sync_found, frame_done, abort, busy
  );
endinterface

// File: rtl/ble_rx_sync_detector.sv
// BLE preamble + access-address correlator with Hamming tolerance; forwards the payload bits.
// Latency: 1 cycle bit_in/bit_valid -> bit_out/bit_out_valid; sync_found 1 cycle after the matching bit.
// Backpressure: none; accepts one bit per cycle back-to-back or with arbitrary gaps.
//
// Ports: clk, reset (sync, active high), bus (ble_rx_sync_detector_if.slave):
//   in : rx_en, access_addr[31:0], payload_bits[LEN_W-1:0], channel[5:0], bit_in, bit_valid
//   out: bit_out, bit_out_valid, sync_found, frame_done, abort, busy
// Optional: define BLE_DEWHITEN_EN to de-whiten payload bits with the channel-seeded 7-bit LFSR.
module ble_rx_sync_detector #(
  parameter int MAX_ERR = 0,
  parameter int LEN_W   = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  ble_rx_sync_detector_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEARCH, PAYLOAD} state_t;

  localparam logic [5:0]       MAX_ERR_C = 6'(MAX_ERR);
  localparam logic [5:0]       FILL_MAX  = 6'd40;
  localparam logic [LEN_W-1:0] LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [39:0]      sr, candidate, expected;
  logic [7:0]       preamble;
  logic [5:0]       fill, err_cnt;
  logic [LEN_W-1:0] len_q, cnt;
  logic             match, take_bit, last_bit, len_zero, clear_sr, w;
  logic             sync_nxt, done_nxt, abort_nxt, ov_nxt, ob_nxt;
  logic             sync_q, done_q, abort_q, ov_q, ob_q;

  function automatic logic [5:0] popcount40(input logic [39:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 40; i++) n = n + {5'd0, v[i]};
    return n;
  endfunction

  // The preamble alternates so that its last bit differs from access_addr[0].
  assign preamble  = bus.access_addr[0] ? 8'h55 : 8'hAA;
  assign expected  = {bus.access_addr, preamble};
  // Correlate against the window that would exist after shifting in this bit.
  assign candidate = {bus.bit_in, sr[39:1]};
  assign err_cnt   = popcount40(candidate ^ expected);
  assign len_zero  = (bus.payload_bits == '0);

  assign match    = (state == SEARCH) && bus.rx_en && bus.bit_valid &&
                    (fill >= 6'd39) && (err_cnt <= MAX_ERR_C);
  assign take_bit = (state == PAYLOAD) && bus.rx_en && bus.bit_valid;
  assign last_bit = (cnt == len_q - LEN_ONE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; rx_en low wins over everything, including a last bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.rx_en) state_nxt = SEARCH;
      SEARCH:  if (!bus.rx_en) state_nxt = IDLE;
               else if (match && !len_zero) state_nxt = PAYLOAD;
      PAYLOAD: if (!bus.rx_en) state_nxt = IDLE;
               else if (take_bit && last_bit) state_nxt = SEARCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    sync_nxt  = match;
    done_nxt  = (match && len_zero) || (take_bit && last_bit);
    abort_nxt = (state == PAYLOAD) && !bus.rx_en;
    ov_nxt    = take_bit;
    ob_nxt    = take_bit & (bus.bit_in ^ w);
    // Every (re)entry into SEARCH starts from an empty correlator window.
    clear_sr  = ((state != SEARCH) && (state_nxt == SEARCH)) || (match && len_zero);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr      <= '0;
      fill    <= '0;
      len_q   <= '0;
      cnt     <= '0;
      sync_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      ov_q    <= 1'b0;
      ob_q    <= 1'b0;
    end else begin
      sync_q  <= sync_nxt;
      done_q  <= done_nxt;
      abort_q <= abort_nxt;
      ov_q    <= ov_nxt;
      ob_q    <= ob_nxt;
      if (clear_sr) begin
        sr   <= '0;
        fill <= '0;
      end else if ((state == SEARCH) && bus.rx_en && bus.bit_valid) begin
        sr <= candidate;
        if (fill != FILL_MAX) fill <= fill + 6'd1;
      end
      if (match) begin
        len_q <= bus.payload_bits;
        cnt   <= '0;
      end else if (take_bit) begin
        cnt <= cnt + LEN_ONE;
      end
    end
  end

`ifdef BLE_DEWHITEN_EN
  logic [6:0] lfsr;

  // x^7 + x^4 + 1, seeded with {channel[0..5], 1}; one step per forwarded bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= '0;
    end else if (match) begin
      lfsr <= {bus.channel[0], bus.channel[1], bus.channel[2],
               bus.channel[3], bus.channel[4], bus.channel[5], 1'b1};
    end else if (take_bit) begin
      lfsr <= {lfsr[5], lfsr[4], lfsr[3] ^ lfsr[6], lfsr[2:0], lfsr[6]};
    end
  end

  assign w = lfsr[6];
`else
  assign w = 1'b0;
`endif

  assign bus.bit_out       = ob_q;
  assign bus.bit_out_valid = ov_q;
  assign bus.sync_found    = sync_q;
  assign bus.frame_done    = done_q;
  assign bus.abort         = abort_q;
  assign bus.busy          = (state == PAYLOAD);

endmodule

// File: tb/tb_ble_rx_sync_detector.sv
module tb_ble_rx_sync_detector;
  localparam int MAX_ERR = 2;
  localparam int LEN_W   = 12;
  localparam logic [31:0] AA = 32'h8E89BED6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ble_rx_sync_detector_if #(.LEN_W(LEN_W)) bus ();
  ble_rx_sync_detector #(.MAX_ERR(MAX_ERR), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  // reference model: mode 0 idle, 1 hunting, 2 forwarding payload
  int m_mode = 0;
  int m_hist[$];
  int m_len = 0;
  int m_idx = 0;
`ifdef BLE_DEWHITEN_EN
  logic [5:0] m_ch = '0;
`endif

  // observed event tallies
  int n_sync, n_done, n_same, n_abort, n_strobe;
  logic [63:0] rx_word;
  int gap_max = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic pattern_bit(input logic [31:0] aa, input int k);
    logic [39:0] p;
    p = {aa, (aa[0] ? 8'h55 : 8'hAA)};
    return p[k];
  endfunction

`ifdef BLE_DEWHITEN_EN
  function automatic logic wbit(input logic [5:0] ch, input int idx);
    logic [6:0] l;
    logic fb;
    l[0] = 1'b1;
    for (int i = 1; i < 7; i++) l[i] = ch[6-i];
    for (int k = 0; k < idx; k++) begin
      fb = l[6];
      l = {l[5:0], fb};
      l[4] = l[4] ^ fb;
    end
    return l[6];
  endfunction
`endif

  function automatic logic [39:0] flips(input int n, input int lo);
    logic [39:0] m;
    int p, c;
    m = '0;
    c = 0;
    while (c < n) begin
      p = int'($urandom_range(39, lo));
      if (!m[p]) begin m[p] = 1'b1; c++; end
    end
    return m;
  endfunction

  task automatic clear_tally();
    n_sync = 0; n_done = 0; n_same = 0; n_abort = 0; n_strobe = 0; rx_word = '0;
  endtask

  // One clock: predict from current inputs, advance, compare every output.
  task automatic tick();
    logic ev, eb, es, ed, ea, ebusy;
    int mism;
    ev = 0; eb = 0; es = 0; ed = 0; ea = 0;
    if (reset) begin
      m_mode = 0;
      m_hist.delete();
    end else begin
      case (m_mode)
        0: if (bus.rx_en) begin m_mode = 1; m_hist.delete(); end
        1: if (!bus.rx_en) m_mode = 0;
           else if (bus.bit_valid) begin
             m_hist.push_back(int'(bus.bit_in));
             if (m_hist.size() > 40) void'(m_hist.pop_front());
             if (m_hist.size() == 40) begin
               mism = 0;
               for (int k = 0; k < 40; k++)
                 if (m_hist[k] != int'(pattern_bit(bus.access_addr, k))) mism++;
               if (mism <= MAX_ERR) begin
                 es = 1;
                 m_len = int'(bus.payload_bits);
                 m_idx = 0;
`ifdef BLE_DEWHITEN_EN
                 m_ch = bus.channel;
`endif
                 if (m_len == 0) begin ed = 1; m_hist.delete(); end
                 else m_mode = 2;
               end
             end
           end
        default: if (!bus.rx_en) begin ea = 1; m_mode = 0; end
           else if (bus.bit_valid) begin
             ev = 1;
             eb = bus.bit_in;
`ifdef BLE_DEWHITEN_EN
             eb = eb ^ wbit(m_ch, m_idx);
`endif
             m_idx++;
             if (m_idx == m_len) begin ed = 1; m_mode = 1; m_hist.delete(); end
           end
      endcase
    end
    ebusy = (m_mode == 2);
    @(posedge clk);
    #1;
    check("outputs", {58'd0, bus.bit_out_valid, bus.bit_out & bus.bit_out_valid, bus.sync_found,
                      bus.frame_done, bus.abort, bus.busy},
          {58'd0, ev, eb, es, ed, ea, ebusy});
    if (bus.sync_found) n_sync++;
    if (bus.frame_done) n_done++;
    if (bus.sync_found && bus.frame_done) n_same++;
    if (bus.abort) n_abort++;
    if (bus.bit_out_valid) begin
      n_strobe++;
      rx_word = {bus.bit_out, rx_word[63:1]};
    end
  endtask

  task automatic idle(input int n);
    bus.bit_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b);
    int g;
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    tick();
    bus.bit_valid = 1'b0;
    g = ($urandom_range(3, 0) == 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (g) tick();
  endtask

  task automatic send_header(input logic [31:0] aa, input logic [39:0] fl);
    bus.access_addr = aa;
    for (int k = 0; k < 40; k++) send_bit(pattern_bit(aa, k) ^ fl[k]);
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    for (int k = 0; k < n; k++) send_bit(w[k]);
  endtask

  logic [31:0] rnd, aa_r;
  int len, nf;

  initial begin
    reset = 1'b1;
    bus.rx_en = 1'b0; bus.access_addr = AA; bus.payload_bits = 12'd32;
    bus.channel = 6'd0; bus.bit_in = 1'b0; bus.bit_valid = 1'b0;
    repeat (3) tick();
    check("reset_state", {58'd0, bus.bit_out_valid, bus.bit_out, bus.sync_found,
                          bus.frame_done, bus.abort, bus.busy}, 64'd0);
    reset = 1'b0;
    idle(2);

    // clean frame, back-to-back bits
    bus.rx_en = 1'b1;
    clear_tally();
    idle(3);
    send_header(AA, 40'd0);
    send_word(32'hDEADBEEF, 32);
    idle(3);
    check("clean_sync", 64'(n_sync), 64'd1);
    check("clean_done", 64'(n_done), 64'd1);
    check("clean_strobes", 64'(n_strobe), 64'd32);
`ifndef BLE_DEWHITEN_EN
    check("clean_word", {32'd0, rx_word[63:32]}, 64'hDEADBEEF);
`endif

    // two AA bits flipped: within tolerance
    gap_max = 3;
    clear_tally();
    send_header(AA, flips(2, 8));
    send_word(32'hDEADBEEF, 32);
    idle(3);
    check("err2_sync", 64'(n_sync), 64'd1);
    check("err2_strobes", 64'(n_strobe), 64'd32);

    // three AA bits flipped: beyond tolerance
    clear_tally();
    send_header(AA, flips(3, 8));
    send_word(32'hDEADBEEF, 32);
    idle(3);
    check("err3_sync", 64'(n_sync), 64'd0);
    check("err3_strobes", 64'(n_strobe), 64'd0);

    // zero-length frame followed by a 16-bit frame
    gap_max = 0;
    clear_tally();
    bus.payload_bits = 12'd0;
    send_header(AA, 40'd0);
    idle(2);
    bus.payload_bits = 12'd16;
    rnd = $urandom;
    send_header(AA, 40'd0);
    send_word(rnd, 16);
    idle(2);
    check("len0_same_cycle", 64'(n_same), 64'd1);
    check("len0_sync", 64'(n_sync), 64'd2);
    check("len0_strobes", 64'(n_strobe), 64'd16);

    // rx_en dropped after 10 payload bits, with a bit presented that cycle
    clear_tally();
    bus.payload_bits = 12'd32;
    send_header(AA, 40'd0);
    send_word($urandom, 10);
    bus.rx_en = 1'b0; bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
    tick();
    idle(2);
    check("abort_pulse", 64'(n_abort), 64'd1);
    check("abort_strobes", 64'(n_strobe), 64'd10);
    check("abort_done", 64'(n_done), 64'd0);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    bus.rx_en = 1'b1;

    // reset in the middle of a payload, then a fresh frame
    clear_tally();
    send_header(AA, 40'd0);
    send_word($urandom, 5);
    reset = 1'b1;
    tick();
    check("midreset_outputs", {58'd0, bus.bit_out_valid, bus.bit_out, bus.sync_found,
                               bus.frame_done, bus.abort, bus.busy}, 64'd0);
    reset = 1'b0;
    idle(2);
    clear_tally();
    rnd = $urandom;
    send_header(AA, 40'd0);
    send_word(rnd, 32);
    idle(2);
    check("postreset_done", 64'(n_done), 64'd1);
`ifndef BLE_DEWHITEN_EN
    check("postreset_word", {32'd0, rx_word[63:32]}, {32'd0, rnd});
`endif

`ifdef BLE_DEWHITEN_EN
    // channel 0 whitening of seven zero bits
    clear_tally();
    bus.channel = 6'd0;
    bus.payload_bits = 12'd7;
    send_header(AA, 40'd0);
    send_word(32'd0, 7);
    idle(2);
    check("dewhiten_ch0", {57'd0, rx_word[63:57]}, 64'h40);
`endif

    // randomized frames: random AA, length, channel, errors, noise, gaps, aborts
    for (int f = 0; f < 16; f++) begin
      gap_max = int'($urandom_range(3, 0));
      bus.payload_bits = 12'($urandom_range(40, 0));
      bus.channel = 6'($urandom_range(63, 0));
      aa_r = $urandom;
      nf = int'($urandom_range(3, 0));
      len = int'(bus.payload_bits);
      repeat ($urandom_range(4, 0)) send_bit(1'($urandom_range(1, 0)));
      send_header(aa_r, flips(nf, 0));
      if (($urandom_range(4, 0) == 0) && (len > 2)) begin
        send_word($urandom, len / 2);
        bus.rx_en = 1'b0;
        tick();
        bus.rx_en = 1'b1;
      end else begin
        for (int k = 0; k < len; k++) send_bit(1'($urandom_range(1, 0)));
      end
      idle(2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
